// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// registers the returned word into IF/ID; halts with a sticky fault on a bad PC.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_BYTES = 400
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        JUMP,
    input  logic [31:0] JUMP_TARGET,
    input  logic [31:0] INSTRUCTION,
    output logic [31:0] READ_ADRESS,
    output logic [31:0] IF_ID_INSTR,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_VALID,
    output logic        FETCH_FAULT,
    output logic [31:0] FAULT_PC
);

    localparam logic [31:0] MAX_PC = 32'(MEM_BYTES - 4);

    typedef enum logic {
        S_RUN,
        S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic [31:0] pc_plus4;
    logic        bad_pc;
    logic        redirect;

    // One adder feeds both the sequential PC and the IF_ID_PC4 capture.
    assign pc_plus4 = pc_q + 32'd4;
    assign bad_pc   = (pc_q[1:0] != 2'b00) || (pc_q > MAX_PC);
    assign redirect = BRANCH_TAKEN || JUMP;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;

        case (state_q)
            S_RUN: begin
                if (bad_pc) begin
                    state_d    = S_FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = pc_q;
                end else if (BRANCH_TAKEN) begin
                    pc_d = BRANCH_TARGET;
                end else if (JUMP) begin
                    pc_d = JUMP_TARGET;
                end else if (!STALL) begin
                    pc_d = pc_plus4;
                end

                if (bad_pc || FLUSH || redirect) begin
                    instr_d = 32'h0;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                end else if (!STALL) begin
                    instr_d = INSTRUCTION;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                end
            end

            S_FAULT: begin
                // Halted: only reset leaves this state, all controls ignored.
                instr_d = 32'h0;
                pc4_d   = 32'h0;
                valid_d = 1'b0;
            end

            default: state_d = S_FAULT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            pc4_q      <= 32'h0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign READ_ADRESS = pc_q;
    assign IF_ID_INSTR = instr_q;
    assign IF_ID_PC4   = pc4_q;
    assign IF_ID_VALID = valid_q;
    assign FETCH_FAULT = fault_q;
    assign FAULT_PC    = fault_pc_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage directly upstream of the byte-addressed instruction memory. It owns the program counter and drives the memory read address. It captures the returned 32-bit big-endian instruction word into an IF/ID pipeline register for the decode stage. It also handles stall, flush, branch/jump redirect and out-of-range/misaligned fetch faults.

## Interface
Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- MEM_BYTES, 400, size of instruction memory in bytes. Highest legal fetch address is MEM_BYTES-4.

Ports:
- CLK  in  1  single clock, all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- STALL  in  1  hold PC and IF/ID contents.
- FLUSH  in  1  replace IF/ID contents with a bubble.
- BRANCH_TAKEN  in  1  redirect PC to BRANCH_TARGET.
- BRANCH_TARGET  in  32  branch destination (byte address).
- JUMP  in  1  redirect PC to JUMP_TARGET.
- JUMP_TARGET  in  32  jump destination (byte address).
- INSTRUCTION  in  32  word returned by instruction memory for READ_ADRESS, same cycle (combinational memory).
- READ_ADRESS  out  32  current PC, driven straight from the PC register.
- IF_ID_INSTR  out  32  registered instruction for decode.
- IF_ID_PC4  out  32  registered PC+4 of that instruction.
- IF_ID_VALID  out  1  IF/ID holds a real instruction.
- FETCH_FAULT  out  1  sticky fault flag.
- FAULT_PC  out  32  PC that caused the fault.

## Operation
- Two states:
  - RUN: normal fetch.
  - FAULT: fetch halted.
- FAULT is left only by RST.
- Fault condition, evaluated in RUN on the current PC: PC[1:0] != 2'b00, or PC > MEM_BYTES-4 (unsigned compare).
- On entering FAULT:
  - FETCH_FAULT <= 1, FAULT_PC <= PC.
  - IF/ID receives a bubble.
  - PC is held.
- In FAULT:
  - PC, FAULT_PC and FETCH_FAULT are frozen.
  - IF/ID is bubbled every cycle.
  - All control inputs are ignored.
- Next-PC priority in RUN, highest first:
  1. fault condition → hold PC.
  2. BRANCH_TAKEN → BRANCH_TARGET.
  3. JUMP → JUMP_TARGET.
  4. STALL → hold PC.
  5. otherwise PC+4 (32-bit, modulo 2^32).
- A redirect (BRANCH_TAKEN or JUMP) overrides STALL, because it comes from an older instruction.
- Redirect targets are not checked when loaded. A bad target faults on the following cycle, when it becomes PC.
- IF/ID update priority in RUN, highest first:
  1. fault condition, FLUSH or any redirect → bubble: IF_ID_INSTR=32'h0 (NOP), IF_ID_PC4=32'h0, IF_ID_VALID=0.
  2. STALL → hold all IF/ID fields.
  3. otherwise IF_ID_INSTR <= INSTRUCTION, IF_ID_PC4 <= PC+4, IF_ID_VALID <= 1.
- FLUSH without redirect or STALL: PC still advances by 4.
- FLUSH with STALL: IF/ID is bubbled and PC is held.
- PC+4 is computed once and shared by the next-PC and IF_ID_PC4 paths.

## Timing
- Reset, asynchronous, takes effect immediately:
  - PC=RESET_PC, so READ_ADRESS=RESET_PC.
  - IF_ID_INSTR=0, IF_ID_PC4=0, IF_ID_VALID=0.
  - FETCH_FAULT=0, FAULT_PC=0, state=RUN.
- Reset asserted mid-operation discards any pending redirect, stall or fault.
- First valid instruction appears in IF/ID at the first rising edge after RST deasserts.
- READ_ADRESS has no combinational path from any input; it changes only on CLK edges or RST.
- Fetch latency: the instruction at PC is in IF/ID one edge after PC is presented.
- Redirect latency:
  - Redirect sampled at edge N → PC=target after N.
  - Target instruction is in IF/ID after edge N+1.
  - IF/ID holds a bubble between N and N+1 (one-bubble penalty).
- Fault timing: bad PC present in the cycle before edge N → FETCH_FAULT=1 after edge N. The bad word is never marked valid.
- Back-to-back redirects on consecutive edges are each honoured, with a bubble each cycle.

## Test plan
- Reset then free-run with RESET_PC=0 → READ_ADRESS 0,4,8,12 on successive cycles. IF_ID_PC4 4,8,12 with VALID=1 from the first edge after reset release.
- STALL high for 2 cycles at PC=8 → READ_ADRESS stays 8. IF/ID holds the word from PC=4 (IF_ID_PC4=8). Fetch resumes at 12 after release.
- BRANCH_TAKEN=1, BRANCH_TARGET=0x40, with JUMP=1, JUMP_TARGET=0x80 and STALL=1 in the same cycle → PC=0x40. IF/ID bubble for one cycle (VALID=0, INSTR=0), then IF_ID_PC4=0x44.
- FLUSH alone at PC=0x10 → IF/ID bubble, PC advances to 0x14, VALID returns to 1 next edge.
- JUMP_TARGET=0x192 (misaligned) → PC=0x192. Next edge: FETCH_FAULT=1, FAULT_PC=0x192, PC frozen, VALID=0 until RST. Repeat with target 396 (no fault) and 400 (fault, FAULT_PC=400).
- Assert RST asynchronously between edges while in FAULT → READ_ADRESS=RESET_PC and FETCH_FAULT=0 immediately, without a clock edge.
